// File: rtl/piso_pkg.sv
// Shared types and frame-size helpers for the PISO serializer.
// Build option: PISO_PARITY_EN appends an even-parity bit to every frame.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Number of serial bits per frame, including the optional parity bit.
   function automatic int frame_len(input int width);
`ifdef PISO_PARITY_EN
      return width + 1;
`else
      return width;
`endif
   endfunction

   function automatic int cnt_width(input int width);
      int n;
      n = $clog2(frame_len(width));
      return (n < 1) ? 1 : n;
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and gapless back-to-back frames.
// Build option: PISO_PARITY_EN appends an even-parity bit (done then marks the parity bit).
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_,
   input  logic [WIDTH-1:0] d,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done,
   output logic             busy
);

   localparam int              FLEN = frame_len(WIDTH);
   localparam int              CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(FLEN - 1);

   state_e            state_q, state_d;
   logic [FLEN-1:0]   shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              sout_q, sout_d;
   logic              sout_valid_q, sout_valid_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic [FLEN-1:0]   frame;
   logic              last_bit;
   logic              accept;

   // frame[0] is the first bit on the wire, so the shifter always pops bit 0.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
         if (MSB_FIRST) begin : g_msb
            assign frame[gi] = d[WIDTH-1-gi];
         end else begin : g_lsb
            assign frame[gi] = d[gi];
         end
      end
   endgenerate

`ifdef PISO_PARITY_EN
   assign frame[FLEN-1] = ^d;
`endif

   assign last_bit   = (state_q == SHIFT) && (cnt_q == LAST);
   assign load_ready = rst_ && ((state_q == IDLE) || last_bit);
   assign accept     = load_valid && load_ready;

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      done_d       = 1'b0;
      busy_d       = busy_q;

      if (accept) begin
         state_d      = SHIFT;
         sout_d       = frame[0];
         shreg_d      = frame >> 1;
         cnt_d        = '0;
         sout_valid_d = 1'b1;
         busy_d       = 1'b1;
      end else if (state_q == SHIFT) begin
         if (last_bit) begin
            state_d      = IDLE;
            shreg_d      = '0;
            cnt_d        = '0;
            sout_d       = 1'b0;
            sout_valid_d = 1'b0;
            busy_d       = 1'b0;
         end else begin
            sout_d  = shreg_q[0];
            shreg_d = shreg_q >> 1;
            cnt_d   = cnt_q + CW'(1);
            done_d  = (cnt_q + CW'(1)) == LAST;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         sout_q       <= 1'b0;
         sout_valid_q <= 1'b0;
         done_q       <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
         done_q       <= done_d;
         busy_q       <= busy_d;
      end
   end

   assign sout       = sout_q;
   assign sout_valid = sout_valid_q;
   assign done       = done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus and are
// compared each cycle against a queue-based frame model plus constant vector tables.
module tb_piso_serializer;

`ifdef PISO_PARITY_EN
   localparam int FL = 5;
   localparam logic [9:0] EXP_B2B = 10'b1011101100;
`else
   localparam int FL = 4;
   localparam logic [9:0] EXP_B2B = 10'b0010110110;
`endif

   typedef bit bitq_t[$];
   typedef struct {
      logic [3:0] d;
      logic [3:0] msb_stream;  // [3] is the first bit sent
      logic [3:0] lsb_stream;
      logic       par;
   } vec_t;

   logic       clk, rst_, load_valid;
   logic [3:0] d;
   logic       ready_m, sout_m, sv_m, done_m, busy_m;
   logic       ready_l, sout_l, sv_l, done_l, busy_l;

   int    checks = 0;
   int    errors = 0;
   bitq_t fbm, fbl;
   vec_t  vecs[6];

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst_(rst_), .d(d), .load_valid(load_valid), .load_ready(ready_m),
      .sout(sout_m), .sout_valid(sv_m), .done(done_m), .busy(busy_m)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst_(rst_), .d(d), .load_valid(load_valid), .load_ready(ready_l),
      .sout(sout_l), .sout_valid(sv_l), .done(done_l), .busy(busy_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bitq_t frame_bits(input logic [3:0] w, input bit msb);
      bitq_t q;
      for (int i = 0; i < 4; i++) q.push_back(msb ? w[3-i] : w[i]);
`ifdef PISO_PARITY_EN
      q.push_back(^w);
`endif
      return q;
   endfunction

   // {sout, sout_valid, done, busy} implied by the bits still owed for the current frame
   function automatic logic [3:0] exp_out(input bitq_t q);
      if (q.size() == 0) return 4'b0000;
      return {q[0], 1'b1, (q.size() == 1), 1'b1};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      logic exp_rdy;
      #1;
      exp_rdy = rst_ && (fbm.size() <= 1);
      chk({tag, " msb outputs"}, {sout_m, sv_m, done_m, busy_m}, exp_out(fbm));
      chk({tag, " msb ready"}, ready_m, exp_rdy);
      chk({tag, " lsb outputs"}, {sout_l, sv_l, done_l, busy_l}, exp_out(fbl));
      chk({tag, " lsb ready"}, ready_l, exp_rdy);
   endtask

   task automatic tick();
      bit acc;
      @(posedge clk);
      acc = load_valid && rst_ && (fbm.size() <= 1);
      if (acc) begin
         fbm = frame_bits(d, 1'b1);
         fbl = frame_bits(d, 1'b0);
         $display("load d=%b at %0t", d, $time);
      end else begin
         if (fbm.size() > 0) void'(fbm.pop_front());
         if (fbl.size() > 0) void'(fbl.pop_front());
      end
      @(negedge clk);
   endtask

   task automatic run_vec(input vec_t v);
      load_valid = 1'b1;
      d          = v.d;
      check_all("vec accept");
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < FL; k++) begin
         d = 4'($urandom);
         check_all("vec bit");
         chk("vec msb bit", sout_m, (k < 4) ? v.msb_stream[3-k] : v.par);
         chk("vec lsb bit", sout_l, (k < 4) ? v.lsb_stream[3-k] : v.par);
         chk("vec done", done_m, (k == FL - 1));
         tick();
      end
      check_all("vec idle");
      chk("vec idle busy", busy_m, 1'b0);
      chk("vec idle ready", ready_m, 1'b1);
   endtask

   task automatic async_reset(input string tag);
      #2 rst_ = 1'b0;
      fbm.delete();
      fbl.delete();
      check_all(tag);
      tick();
      rst_ = 1'b1;
   endtask

   initial begin
      logic [9:0] stream;
      int         vcount, dcount;

      vecs[0] = '{4'b1011, 4'b1011, 4'b1101, 1'b1};
      vecs[1] = '{4'b0110, 4'b0110, 4'b0110, 1'b0};
      vecs[2] = '{4'b1000, 4'b1000, 4'b0001, 1'b1};
      vecs[3] = '{4'b0001, 4'b0001, 4'b1000, 1'b1};
      vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b0};
      vecs[5] = '{4'b0101, 4'b0101, 4'b1010, 1'b0};

      rst_       = 1'b0;
      load_valid = 1'b1;
      d          = 4'b1011;
      check_all("reset");
      chk("reset ready forced low", ready_m, 1'b0);
      tick();
      load_valid = 1'b0;
      rst_       = 1'b1;
      check_all("after reset");

      foreach (vecs[i]) run_vec(vecs[i]);

      // back-to-back: second word presented during the last-bit cycle
      stream = '0; vcount = 0; dcount = 0;
      load_valid = 1'b1; d = 4'b1011;
      check_all("b2b accept");
      tick();
      for (int c = 1; c <= 2 * FL; c++) begin
         load_valid = (c == FL);
         d          = (c == FL) ? 4'b0110 : 4'($urandom);
         check_all("b2b");
         if (sv_m) begin
            stream = {stream[8:0], sout_m};
            vcount++;
         end
         if (done_m) begin
            dcount++;
            chk("b2b done position", c % FL, 0);
         end
         tick();
      end
      check_all("b2b idle");
      chk("b2b stream", stream, EXP_B2B);
      chk("b2b valid count", vcount, 2 * FL);
      chk("b2b done count", dcount, 2);

      // hold-off: load_valid stays high while a frame is in flight
      load_valid = 1'b1; d = 4'b1011;
      check_all("hold accept");
      tick();
      for (int c = 1; c < FL; c++) begin
         d = (c == 1) ? 4'b1111 : 4'($urandom);
         check_all("hold busy");
         chk("hold ready low", ready_m, 1'b0);
         chk("hold msb bit", sout_m, vecs[0].msb_stream[4-c]);
         tick();
      end
      d = 4'b1111;
      check_all("hold capture");
      chk("hold ready high", ready_m, 1'b1);
      tick();
      load_valid = 1'b0;
      for (int k = 0; k < FL; k++) begin
         check_all("hold next frame");
         chk("hold next bit", sout_m, (k < 4) ? 1'b1 : 1'b0);
         tick();
      end
      check_all("hold idle");

      // reset during the second bit of a frame
      load_valid = 1'b1; d = 4'b1011;
      check_all("rst accept");
      tick();
      load_valid = 1'b0;
      check_all("rst bit1");
      tick();
      check_all("rst bit2");
      async_reset("rst mid-frame");
      chk("rst outputs cleared", {sout_m, sv_m, done_m, busy_m}, 4'b0000);
      check_all("rst released");
      chk("rst ready after release", ready_m, 1'b1);
      run_vec(vecs[0]);

      // randomized traffic against the frame model
      for (int n = 0; n < 400; n++) begin
         load_valid = ($urandom_range(0, 99) < 60);
         d          = 4'($urandom);
         check_all("rand");
         if ($urandom_range(0, 99) < 2) async_reset("rand reset");
         else tick();
      end
      load_valid = 1'b0;
      for (int n = 0; n < FL + 1; n++) begin
         check_all("drain");
         tick();
      end
      check_all("final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
